// File: rtl/alu_issue_stage.sv
// alu_issue_stage: RV32I OP/OP-IMM decode and operand fetch feeding the ALU.
// One registered output slot (valid/ready); ALU results return through the write-back port.
module alu_issue_stage #(
   parameter int unsigned CNT_W  = 16,
   parameter bit          BYPASS = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [31:0]      in_instr,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       out_alu_op,
   output logic [31:0]      out_a,
   output logic [31:0]      out_b,
   output logic [4:0]       out_rd,
   input  logic             wb_en,
   input  logic [4:0]       wb_addr,
   input  logic [31:0]      wb_data,
   output logic             illegal,
   output logic [CNT_W-1:0] illegal_cnt
);

   typedef enum logic [3:0] {
      ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010,
      ALU_OR  = 4'b0011, ALU_XOR = 4'b0100, ALU_SLL = 4'b0101,
      ALU_SRL = 4'b0110, ALU_SRA = 4'b0111, ALU_SLT = 4'b1000
   } alu_op_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] F7_ZERO    = 7'b0000000;
   localparam logic [6:0] F7_ALT     = 7'b0100000;

   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
   logic [4:0]  rs1, rs2;
   logic [31:0] imm;

   assign opcode = in_instr[6:0];
   assign funct3 = in_instr[14:12];
   assign funct7 = in_instr[31:25];
   assign rs1    = in_instr[19:15];
   assign rs2    = in_instr[24:20];
   assign imm    = {{20{in_instr[31]}}, in_instr[31:20]};

   logic    dec_legal, dec_imm;
   alu_op_e dec_op;

   // NOTE: every output of a combinational block gets a default first so no path infers a latch.
   always_comb begin
      dec_legal = 1'b0;
      dec_imm   = 1'b0;
      dec_op    = ALU_ADD;
      case (opcode)
         OPC_OP: begin
            dec_legal = 1'b1;
            case ({funct7, funct3})
               {F7_ZERO, 3'b000}: dec_op = ALU_ADD;
               {F7_ALT,  3'b000}: dec_op = ALU_SUB;
               {F7_ZERO, 3'b001}: dec_op = ALU_SLL;
               {F7_ZERO, 3'b010}: dec_op = ALU_SLT;
               {F7_ZERO, 3'b100}: dec_op = ALU_XOR;
               {F7_ZERO, 3'b101}: dec_op = ALU_SRL;
               {F7_ALT,  3'b101}: dec_op = ALU_SRA;
               {F7_ZERO, 3'b110}: dec_op = ALU_OR;
               {F7_ZERO, 3'b111}: dec_op = ALU_AND;
               default:           dec_legal = 1'b0;
            endcase
         end
         OPC_OP_IMM: begin
            dec_imm   = 1'b1;
            dec_legal = 1'b1;
            case (funct3)
               3'b000: dec_op = ALU_ADD;
               3'b010: dec_op = ALU_SLT;
               3'b100: dec_op = ALU_XOR;
               3'b110: dec_op = ALU_OR;
               3'b111: dec_op = ALU_AND;
               3'b001: begin
                  dec_op    = ALU_SLL;
                  dec_legal = (funct7 == F7_ZERO);
               end
               3'b101: begin
                  if (funct7 == F7_ALT) dec_op = ALU_SRA;
                  else                  dec_op = ALU_SRL;
                  dec_legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
               end
               default: dec_legal = 1'b0;
            endcase
         end
         default: dec_legal = 1'b0;
      endcase
   end

   logic [31:0]      regs_q [32];
   logic [31:0]      regs_d [32];
   logic             valid_q, valid_d, illegal_q, illegal_d;
   logic [3:0]       op_q, op_d;
   logic [31:0]      a_q, a_d, b_q, b_d;
   logic [4:0]       rd_q, rd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             accept;

   // x0 is hard zero; a same-cycle write-back can be forwarded when BYPASS is set.
   function automatic logic [31:0] read_reg(input logic [4:0] idx);
      if (idx == 5'd0)                             return 32'd0;
      else if (BYPASS && wb_en && wb_addr == idx) return wb_data;
      else                                         return regs_q[idx];
   endfunction

   always_comb begin
      in_ready  = !valid_q || out_ready;
      accept    = in_valid && in_ready;
      valid_d   = valid_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      rd_d      = rd_q;
      illegal_d = 1'b0;
      cnt_d     = cnt_q;
      regs_d    = regs_q;
      if (accept && dec_legal) begin
         valid_d = 1'b1;
         op_d    = dec_op;
         a_d     = read_reg(rs1);
         b_d     = dec_imm ? imm : read_reg(rs2);
         rd_d    = in_instr[11:7];
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
      if (accept && !dec_legal) begin
         illegal_d = 1'b1;
         if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      end
      if (wb_en && wb_addr != 5'd0) regs_d[wb_addr] = wb_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q   <= 1'b0;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         rd_q      <= '0;
         illegal_q <= 1'b0;
         cnt_q     <= '0;
         // NOTE: the register file is a flop array that must read zero after reset, so it is cleared here.
         for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      end else begin
         valid_q   <= valid_d;
         op_q      <= op_d;
         a_q       <= a_d;
         b_q       <= b_d;
         rd_q      <= rd_d;
         illegal_q <= illegal_d;
         cnt_q     <= cnt_d;
         regs_q    <= regs_d;
      end
   end

   assign out_valid   = valid_q;
   assign out_alu_op  = op_q;
   assign out_a       = a_q;
   assign out_b       = b_q;
   assign out_rd      = rd_q;
   assign illegal     = illegal_q;
   assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed stimulus with a table-driven reference model compared every cycle.
// A second instance with BYPASS=0 checks the non-forwarding read.
module tb_alu_issue_stage;

   localparam int unsigned CNT_W   = 4;
   localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst, in_valid, out_ready, wb_en;
   logic [31:0]      in_instr, wb_data;
   logic [4:0]       wb_addr;
   logic             in_ready, out_valid, illegal;
   logic [3:0]       out_alu_op;
   logic [31:0]      out_a, out_b;
   logic [4:0]       out_rd;
   logic [CNT_W-1:0] illegal_cnt;

   logic             nb_in_ready, nb_out_valid, nb_illegal;
   logic [3:0]       nb_alu_op;
   logic [31:0]      nb_a, nb_b;
   logic [4:0]       nb_rd;
   logic [15:0]      nb_cnt;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   alu_issue_stage #(.CNT_W(CNT_W), .BYPASS(1'b1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready), .out_alu_op(out_alu_op), .out_a(out_a),
      .out_b(out_b), .out_rd(out_rd), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .illegal(illegal), .illegal_cnt(illegal_cnt)
   );

   alu_issue_stage #(.CNT_W(16), .BYPASS(1'b0)) dut_nb (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(nb_in_ready),
      .out_valid(nb_out_valid), .out_ready(out_ready), .out_alu_op(nb_alu_op), .out_a(nb_a),
      .out_b(nb_b), .out_rd(nb_rd), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .illegal(nb_illegal), .illegal_cnt(nb_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] r_ins(input logic [6:0] f7, input logic [4:0] s2,
                                         input logic [4:0] s1, input logic [2:0] f3,
                                         input logic [4:0] d);
      return {f7, s2, s1, f3, d, 7'b0110011};
   endfunction

   function automatic logic [31:0] i_ins(input logic [11:0] im, input logic [4:0] s1,
                                         input logic [2:0] f3, input logic [4:0] d);
      return {im, s1, f3, d, 7'b0010011};
   endfunction

   // Reference model: the legal-instruction list as a lookup table, plus architectural state.
   typedef struct {
      logic [6:0] opc;
      logic [2:0] f3;
      bit         use_f7;
      logic [6:0] f7;
      logic [3:0] op;
   } dec_ent_t;

   dec_ent_t dec_tab[16];

   initial begin
      dec_tab[0]  = '{7'h33, 3'd0, 1, 7'h00, 4'd0};
      dec_tab[1]  = '{7'h33, 3'd0, 1, 7'h20, 4'd1};
      dec_tab[2]  = '{7'h33, 3'd1, 1, 7'h00, 4'd5};
      dec_tab[3]  = '{7'h33, 3'd2, 1, 7'h00, 4'd8};
      dec_tab[4]  = '{7'h33, 3'd4, 1, 7'h00, 4'd4};
      dec_tab[5]  = '{7'h33, 3'd5, 1, 7'h00, 4'd6};
      dec_tab[6]  = '{7'h33, 3'd5, 1, 7'h20, 4'd7};
      dec_tab[7]  = '{7'h33, 3'd6, 1, 7'h00, 4'd3};
      dec_tab[8]  = '{7'h33, 3'd7, 1, 7'h00, 4'd2};
      dec_tab[9]  = '{7'h13, 3'd0, 0, 7'h00, 4'd0};
      dec_tab[10] = '{7'h13, 3'd2, 0, 7'h00, 4'd8};
      dec_tab[11] = '{7'h13, 3'd4, 0, 7'h00, 4'd4};
      dec_tab[12] = '{7'h13, 3'd6, 0, 7'h00, 4'd3};
      dec_tab[13] = '{7'h13, 3'd7, 0, 7'h00, 4'd2};
      dec_tab[14] = '{7'h13, 3'd1, 1, 7'h00, 4'd5};
      dec_tab[15] = '{7'h13, 3'd5, 1, 7'h00, 4'd6};
   end

   logic [31:0] m_regs [32];
   bit          m_valid, m_illegal;
   logic [3:0]  m_op;
   logic [31:0] m_a, m_b;
   logic [4:0]  m_rd;
   int unsigned m_cnt;

   function automatic logic [31:0] m_read(input logic [4:0] idx);
      if (idx == 0) return 32'd0;
      if (wb_en && wb_addr == idx) return wb_data;
      return m_regs[idx];
   endfunction

   always @(posedge clk) begin
      bit         acc, legal;
      logic [3:0] op;
      if (rst) begin
         m_valid = 0; m_illegal = 0; m_cnt = 0;
         m_op = 0; m_a = 0; m_b = 0; m_rd = 0;
         for (int i = 0; i < 32; i++) m_regs[i] = 0;
      end else begin
         acc   = in_valid && (!m_valid || out_ready);
         legal = 0;
         op    = 0;
         for (int i = 0; i < 16; i++)
            if (in_instr[6:0] == dec_tab[i].opc && in_instr[14:12] == dec_tab[i].f3 &&
                (!dec_tab[i].use_f7 || in_instr[31:25] == dec_tab[i].f7)) begin
               legal = 1;
               op    = dec_tab[i].op;
            end
         // srai shares funct3 with srli but needs its own funct7
         if (in_instr[6:0] == 7'h13 && in_instr[14:12] == 3'd5 && in_instr[31:25] == 7'h20) begin
            legal = 1;
            op    = 4'd7;
         end
         if (acc && legal) begin
            m_valid = 1;
            m_op    = op;
            m_a     = m_read(in_instr[19:15]);
            m_b     = (in_instr[6:0] == 7'h13) ? 32'($signed(in_instr[31:20]))
                                               : m_read(in_instr[24:20]);
            m_rd    = in_instr[11:7];
         end else if (out_ready) begin
            m_valid = 0;
         end
         m_illegal = acc && !legal;
         if (m_illegal && m_cnt < CNT_MAX) m_cnt++;
         if (wb_en && wb_addr != 0) m_regs[wb_addr] = wb_data;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("in_ready", {31'd0, in_ready}, {31'd0, !m_valid || out_ready});
         check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
         check("illegal", {31'd0, illegal}, {31'd0, m_illegal});
         check("illegal_cnt", 32'(illegal_cnt), m_cnt);
         if (m_valid) begin
            check("out_alu_op", 32'(out_alu_op), 32'(m_op));
            check("out_a", out_a, m_a);
            check("out_b", out_b, m_b);
            check("out_rd", 32'(out_rd), 32'(m_rd));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wb(input logic [4:0] adr, input logic [31:0] dat);
      wb_en = 1; wb_addr = adr; wb_data = dat;
      step();
      wb_en = 0;
   endtask

   logic [31:0] vec [20];

   initial begin
      rst = 1; in_valid = 0; in_instr = 0; out_ready = 1; wb_en = 0; wb_addr = 0; wb_data = 0;
      step(); step();
      rst = 0;
      chk_en = 1;
      check("rst out_valid", {31'd0, out_valid}, 32'd0);
      check("rst out_alu_op", 32'(out_alu_op), 32'd0);
      check("rst out_a", out_a, 32'd0);
      check("rst out_b", out_b, 32'd0);
      check("rst out_rd", 32'(out_rd), 32'd0);
      check("rst illegal", {31'd0, illegal}, 32'd0);
      check("rst illegal_cnt", 32'(illegal_cnt), 32'd0);

      // addi x1,x0,5
      in_valid = 1; in_instr = 32'h0050_0093;
      step();
      in_valid = 0;
      check("addi valid", {31'd0, out_valid}, 32'd1);
      check("addi op", 32'(out_alu_op), 32'd0);
      check("addi a", out_a, 32'd0);
      check("addi b", out_b, 32'd5);
      check("addi rd", 32'(out_rd), 32'd1);
      check("addi illegal", {31'd0, illegal}, 32'd0);

      // sub x4,x1,x2 with x2 written in the accept cycle
      wb(5'd1, 32'd7);
      wb(5'd2, 32'd3);
      in_valid = 1; in_instr = 32'h4020_8233;
      wb_en = 1; wb_addr = 5'd2; wb_data = 32'd9;
      step();
      in_valid = 0; wb_en = 0;
      check("sub op", 32'(out_alu_op), 32'd1);
      check("sub a", out_a, 32'd7);
      check("sub b bypass", out_b, 32'd9);
      check("sub rd", 32'(out_rd), 32'd4);
      check("sub b no-bypass", nb_b, 32'd3);

      // hold the sub for three cycles while addi x3,x0,1 waits
      out_ready = 0; in_valid = 1; in_instr = 32'h0010_0193;
      for (int i = 0; i < 3; i++) begin
         step();
         check("hold in_ready", {31'd0, in_ready}, 32'd0);
         check("hold rd", 32'(out_rd), 32'd4);
         check("hold a", out_a, 32'd7);
      end
      out_ready = 1;
      step();
      in_valid = 0;
      check("release valid", {31'd0, out_valid}, 32'd1);
      check("release rd", 32'(out_rd), 32'd3);
      check("release b", out_b, 32'd1);
      step();
      check("no duplicate", {31'd0, out_valid}, 32'd0);

      // sltu is illegal; then saturate the counter with a mix of unsupported encodings
      in_valid = 1; in_instr = 32'h0020_B1B3;
      step();
      in_valid = 0;
      check("sltu illegal", {31'd0, illegal}, 32'd1);
      check("sltu no valid", {31'd0, out_valid}, 32'd0);
      check("sltu cnt", 32'(illegal_cnt), 32'd1);
      step();
      check("illegal pulse end", {31'd0, illegal}, 32'd0);
      in_valid = 1;
      for (int i = 0; i < 18; i++) begin
         case (i % 4)
            0: in_instr = 32'h0020_B1B3;
            1: in_instr = 32'h0000_A083;
            2: in_instr = i_ins(12'h005, 5'd1, 3'd3, 5'd2);
            default: in_instr = i_ins(12'h403, 5'd1, 3'd1, 5'd2);
         endcase
         step();
         if (i == 2) check("cnt mid", 32'(illegal_cnt), 32'd4);
      end
      in_valid = 0;
      check("cnt saturated", 32'(illegal_cnt), CNT_MAX);
      step();
      check("cnt holds", 32'(illegal_cnt), CNT_MAX);

      // srai x2,x1,3
      wb(5'd1, 32'hF000_0000);
      in_valid = 1; in_instr = 32'h4030_D113;
      step();
      in_valid = 0;
      check("srai op", 32'(out_alu_op), 32'd7);
      check("srai a", out_a, 32'hF000_0000);
      check("srai b", out_b, 32'h0000_0403);
      check("srai rd", 32'(out_rd), 32'd2);

      // mixed vectors with concurrent write-back and back-pressure
      wb(5'd5, 32'h8000_0001);
      wb(5'd6, 32'h0000_0004);
      vec[0]  = r_ins(7'h00, 5'd6, 5'd5, 3'd0, 5'd7);
      vec[1]  = r_ins(7'h20, 5'd6, 5'd5, 3'd0, 5'd7);
      vec[2]  = r_ins(7'h00, 5'd6, 5'd5, 3'd7, 5'd8);
      vec[3]  = r_ins(7'h00, 5'd6, 5'd5, 3'd6, 5'd9);
      vec[4]  = r_ins(7'h00, 5'd6, 5'd5, 3'd4, 5'd10);
      vec[5]  = r_ins(7'h00, 5'd6, 5'd5, 3'd1, 5'd11);
      vec[6]  = r_ins(7'h00, 5'd6, 5'd5, 3'd5, 5'd12);
      vec[7]  = r_ins(7'h20, 5'd6, 5'd5, 3'd5, 5'd13);
      vec[8]  = r_ins(7'h00, 5'd6, 5'd5, 3'd2, 5'd14);
      vec[9]  = i_ins(12'hFFF, 5'd5, 3'd0, 5'd15);
      vec[10] = i_ins(12'h800, 5'd5, 3'd2, 5'd16);
      vec[11] = i_ins(12'h0F0, 5'd6, 3'd4, 5'd17);
      vec[12] = i_ins(12'h7FF, 5'd5, 3'd6, 5'd18);
      vec[13] = i_ins(12'hF0F, 5'd5, 3'd7, 5'd19);
      vec[14] = i_ins(12'h01F, 5'd5, 3'd1, 5'd20);
      vec[15] = i_ins(12'h004, 5'd5, 3'd5, 5'd21);
      vec[16] = i_ins(12'h404, 5'd5, 3'd5, 5'd22);
      vec[17] = r_ins(7'h00, 5'd6, 5'd5, 3'd0, 5'd0);
      vec[18] = r_ins(7'h01, 5'd6, 5'd5, 3'd0, 5'd7);
      vec[19] = r_ins(7'h00, 5'd0, 5'd0, 3'd6, 5'd23);
      for (int i = 0; i < 20; i++) begin
         in_valid  = 1;
         in_instr  = vec[i];
         out_ready = (i % 3 != 2);
         wb_en     = i[0];
         wb_addr   = (i % 4 == 3) ? 5'd0 : 5'd5;
         wb_data   = 32'h1000_0000 * i + i;
         step();
      end
      in_valid = 0; wb_en = 0; out_ready = 1;
      step();

      // reset while the slot is occupied and stalled; write-back during reset is ignored
      in_valid = 1; in_instr = r_ins(7'h00, 5'd6, 5'd5, 3'd0, 5'd9); out_ready = 0;
      step();
      check("pre-rst valid", {31'd0, out_valid}, 32'd1);
      rst = 1; wb_en = 1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
      step();
      rst = 0; wb_en = 0; in_valid = 0;
      check("post-rst valid", {31'd0, out_valid}, 32'd0);
      check("post-rst cnt", 32'(illegal_cnt), 32'd0);
      check("post-rst illegal", {31'd0, illegal}, 32'd0);
      out_ready = 1; in_valid = 1;
      for (int i = 1; i < 32; i++) begin
         in_instr = r_ins(7'h00, 5'(i), 5'(i), 3'd0, 5'd1);
         step();
         check("post-rst reg a", out_a, 32'd0);
         check("post-rst reg b", out_b, 32'd0);
      end
      in_valid = 0;
      step(); step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
